// File: rtl/jtcop_mcu_bridge.sv
// Command FIFO / INT1 handshake and 16-bit response latch between the 68000 and the i8751 MCU.
// Optional INT1 acknowledge watchdog enabled by defining JTCOP_MCU_TIMEOUT_EN.
module jtcop_mcu_bridge #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] main_din,
  input  logic        main_we,
  input  logic        main_re,
  input  logic [2:0]  sel_hi,
  output logic [15:0] main_dout,
  output logic        rsp_valid,
  output logic        cmd_full,
  input  logic [7:0]  p0_o,
  input  logic [7:0]  p2_o,
  input  logic [7:0]  p3_o,
  output logic [7:0]  p0_i,
  output logic [7:0]  p3_i,
  output logic        int1n,
  output logic        mcu_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) ptr_inc = {AW{1'b0}};
    else                     ptr_inc = p + AW'(1);
  endfunction

  logic              we_q, re_q;
  logic [7:0]        p2_q;
  logic [15:0]       mem_q [DEPTH];
  logic [15:0]       mem_d [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              full_q, full_d;
  state_t            state_q, state_d;
  logic              int1n_q, int1n_d;
  logic [7:0]        p0_i_q, p0_i_d;
  logic [15:0]       dout_q, dout_d;
  logic              rsp_q, rsp_d;

  logic              we_rise_s, re_rise_s, push_s, pop_s, empty_s;
  logic [7:0]        p2_rise_s;
  logic [15:0]       head_s;
  logic              unused_s;

  assign we_rise_s = main_we & ~we_q;
  assign re_rise_s = main_re & ~re_q;
  assign p2_rise_s = p2_o & ~p2_q;
  assign empty_s   = (cnt_q == {CW{1'b0}});
  assign head_s    = mem_q[rd_ptr_q];
  assign push_s    = we_rise_s && (cnt_q != CW'(DEPTH));

`ifdef JTCOP_MCU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  // Handshake FSM: INT1 is requested while REQ, dropped once the MCU acknowledges
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
`ifdef JTCOP_MCU_TIMEOUT_EN
    err_d   = err_q;
    tmo_d   = (state_q == ST_REQ) ? (tmo_q + TW'(1)) : {TW{1'b0}};
`endif
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) state_d = ST_REQ;
        else          state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (!p2_o[3]) begin
          state_d = ST_SERV;
`ifdef JTCOP_MCU_TIMEOUT_EN
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // MCU ignored the request: drop the command and flag it
          state_d = ST_IDLE;
          pop_s   = 1'b1;
          err_d   = 1'b1;
`endif
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SERV: begin
        if (p2_rise_s[5]) begin
          state_d = ST_IDLE;
          pop_s   = 1'b1;
        end else begin
          state_d = ST_SERV;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    int1n_d = (state_d != ST_REQ);
  end

  // Command FIFO bookkeeping; a push into a full FIFO is discarded
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = main_din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) rd_ptr_d = ptr_inc(rd_ptr_q);
    else       rd_ptr_d = rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == CW'(DEPTH));
  end

  // MCU port reads of the head word and response assembly for the main CPU
  always_comb begin
    p0_i_d = p0_i_q;
    dout_d = dout_q;
    rsp_d  = rsp_q;
    if (p2_rise_s[5])      p0_i_d = empty_s ? 8'hFF : head_s[7:0];
    else if (p2_rise_s[4]) p0_i_d = empty_s ? 8'hFF : head_s[15:8];
    else                   p0_i_d = p0_i_q;
    if (p2_rise_s[6]) dout_d[7:0]  = p0_o;
    else              dout_d[7:0]  = dout_q[7:0];
    if (p2_rise_s[7]) dout_d[15:8] = p0_o;
    else              dout_d[15:8] = dout_q[15:8];
    // a fresh response beats a simultaneous read
    if (p2_rise_s[7])   rsp_d = 1'b1;
    else if (re_rise_s) rsp_d = 1'b0;
    else                rsp_d = rsp_q;
  end

  // State registers; edge copies reset high so release never looks like a rise
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q     <= 1'b1;
      re_q     <= 1'b1;
      p2_q     <= 8'hFF;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'h0000;
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      full_q   <= 1'b0;
      state_q  <= ST_IDLE;
      int1n_q  <= 1'b1;
      p0_i_q   <= 8'h00;
      dout_q   <= 16'h0000;
      rsp_q    <= 1'b0;
    end else begin
      we_q     <= main_we;
      re_q     <= main_re;
      p2_q     <= p2_o;
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      state_q  <= state_d;
      int1n_q  <= int1n_d;
      p0_i_q   <= p0_i_d;
      dout_q   <= dout_d;
      rsp_q    <= rsp_d;
    end
  end

`ifdef JTCOP_MCU_TIMEOUT_EN
  // Watchdog counter and sticky error flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_q <= {TW{1'b0}};
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign mcu_err  = err_q;
  assign unused_s = ^{p3_o[7:5], p2_rise_s[3:0]};
`else
  assign mcu_err  = 1'b0;
  assign unused_s = ^{p3_o[7:5], p2_rise_s[3:0], 1'(TIMEOUT)};
`endif

  assign main_dout = dout_q;
  assign rsp_valid = rsp_q;
  assign cmd_full  = full_q;
  assign p0_i      = p0_i_q;
  assign int1n     = int1n_q;
  assign p3_i      = {sel_hi, p3_o[4:0]};

endmodule

// File: tb/tb_jtcop_mcu_bridge.sv
// Randomized bench for jtcop_mcu_bridge: the bench plays both CPUs and checks against a queue model.
module tb_jtcop_mcu_bridge;
  localparam int DEPTH = 4;

  logic        clk, rstn;
  logic [15:0] main_din, main_dout;
  logic        main_we, main_re, rsp_valid, cmd_full, int1n, mcu_err;
  logic [2:0]  sel_hi;
  logic [7:0]  p0_o, p2_o, p3_o, p0_i, p3_i;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] model_q[$];
  logic [15:0] exp_dout;
  logic        exp_rsp;
  logic        i1;

  jtcop_mcu_bridge #(.DEPTH(DEPTH), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .main_din(main_din), .main_we(main_we), .main_re(main_re),
    .sel_hi(sel_hi), .main_dout(main_dout), .rsp_valid(rsp_valid), .cmd_full(cmd_full),
    .p0_o(p0_o), .p2_o(p2_o), .p3_o(p3_o), .p0_i(p0_i), .p3_i(p3_i),
    .int1n(int1n), .mcu_err(mcu_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check_p3;
    logic [2:0] s;
    logic [7:0] p;
    s = 3'($urandom);
    p = 8'($urandom);
    sel_hi = s;
    p3_o   = p;
    #1;
    check_val("p3_i", 32'(p3_i), 32'({s, p[4:0]}));
  endtask

  task automatic push_word(input logic [15:0] w, output logic int1n_a);
    main_din = w;
    main_we  = 1'b1;
    tick;
    int1n_a = int1n;
    if (model_q.size() < DEPTH) model_q.push_back(w);
    check_val("cmd_full", 32'(cmd_full), 32'(model_q.size() == DEPTH));
    main_we = 1'b0;
    tick;
  endtask

  task automatic service;
    int k;
    logic [15:0] h;
    if (model_q.size() == 0) return;
    k = 0;
    while (int1n !== 1'b0 && k < 40) begin
      tick;
      k++;
    end
    check_val("int1n_req", 32'(int1n), 32'(0));
    h = model_q[0];
    p2_o[3] = 1'b0;
    tick;
    check_val("int1n_ack", 32'(int1n), 32'(1));
    p2_o[3] = 1'b1;
    p2_o[4] = 1'b1;
    tick;
    check_val("p0_hi", 32'(p0_i), 32'(h[15:8]));
    p2_o[5] = 1'b1;
    tick;
    check_val("p0_lo", 32'(p0_i), 32'(h[7:0]));
    void'(model_q.pop_front());
    check_val("full_pop", 32'(cmd_full), 32'(0));
    check_val("int1n_idle", 32'(int1n), 32'(1));
    p2_o[4] = 1'b0;
    p2_o[5] = 1'b0;
    tick;
    check_val("int1n_next", 32'(int1n), 32'(model_q.size() == 0));
  endtask

  task automatic respond(input logic [7:0] lo, input logic [7:0] hi, input logic coincide);
    p0_o    = lo;
    p2_o[6] = 1'b1;
    tick;
    p2_o[6] = 1'b0;
    p0_o    = hi;
    p2_o[7] = 1'b1;
    main_re = coincide;
    tick;
    p2_o[7]  = 1'b0;
    main_re  = 1'b0;
    exp_dout = {hi, lo};
    exp_rsp  = 1'b1;
    check_val("dout", 32'(main_dout), 32'(exp_dout));
    check_val(coincide ? "rsp_coinc" : "rsp_set", 32'(rsp_valid), 32'(exp_rsp));
    tick;
  endtask

  task automatic main_read;
    main_re = 1'b1;
    tick;
    main_re = 1'b0;
    exp_rsp = 1'b0;
    check_val("rsp_clr", 32'(rsp_valid), 32'(exp_rsp));
    check_val("dout_hold", 32'(main_dout), 32'(exp_dout));
    tick;
  endtask

  task automatic empty_read;
    p2_o[4] = 1'b1;
    tick;
    check_val("p0_empty", 32'(p0_i), 32'(8'hFF));
    p2_o[4] = 1'b0;
    tick;
  endtask

  initial begin
    logic [15:0] w;
    int n;
    rstn = 1'b0; main_we = 1'b1; main_re = 1'b1; p2_o = 8'hFF;
    p0_o = 8'h00; p3_o = 8'h00; sel_hi = 3'd0; main_din = 16'h0000;
    exp_dout = 16'h0000; exp_rsp = 1'b0;
    repeat (3) tick;
    rstn = 1'b1;
    repeat (4) tick;
    check_val("rst_int1n", 32'(int1n), 32'(1));
    check_val("rst_rsp", 32'(rsp_valid), 32'(0));
    check_val("rst_p0i", 32'(p0_i), 32'(0));
    check_val("rst_dout", 32'(main_dout), 32'(0));
    check_val("rst_full", 32'(cmd_full), 32'(0));
    check_val("rst_err", 32'(mcu_err), 32'(0));
    main_we = 1'b0; main_re = 1'b0; p2_o = 8'h08;
    repeat (2) tick;
    check_val("rst_noreq", 32'(int1n), 32'(1));
    check_p3;

    // single command, INT1 latency
    push_word(16'h1234, i1);
    check_val("int1n_a", 32'(i1), 32'(1));
    check_val("int1n_b", 32'(int1n), 32'(0));
    service;
    empty_read;

    // both read strobes together outside SERV: low byte, no pop
    push_word(16'hBEEF, i1);
    p2_o[4] = 1'b1; p2_o[5] = 1'b1;
    tick;
    check_val("p0_both", 32'(p0_i), 32'(8'hEF));
    p2_o[4] = 1'b0; p2_o[5] = 1'b0;
    tick;
    service;

    // overflow: fifth word dropped
    for (int i = 1; i <= 5; i++) push_word(16'(i), i1);
    for (int i = 0; i < 4; i++) service;
    repeat (3) tick;
    check_val("drained", 32'(int1n), 32'(1));
    empty_read;

    respond(8'hCD, 8'hAB, 1'b0);
    main_read;
    respond(8'($urandom), 8'($urandom), 1'b1);
    main_read;

    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 5))
        0, 1: push_word(16'($urandom), i1);
        2: service;
        3: respond(8'($urandom), 8'($urandom), 1'($urandom));
        4: main_read;
        default: begin
          if (model_q.size() == 0) empty_read;
          else check_p3;
        end
      endcase
    end
    while (model_q.size() > 0) service;

    // reset while serving with two words queued
    push_word(16'h1111, i1);
    push_word(16'h2222, i1);
    n = 0;
    while (int1n !== 1'b0 && n < 40) begin
      tick;
      n++;
    end
    p2_o[3] = 1'b0;
    tick;
    p2_o[3] = 1'b1;
    push_word(16'h3333, i1);
    void'(model_q.pop_front());
    p2_o[3] = 1'b0;
    tick;
    p2_o[3] = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check_val("rst_async_int1n", 32'(int1n), 32'(1));
    model_q.delete();
    exp_dout = 16'h0000;
    exp_rsp  = 1'b0;
    repeat (2) tick;
    rstn = 1'b1;
    repeat (4) tick;
    check_val("rst2_int1n", 32'(int1n), 32'(1));
    check_val("rst2_full", 32'(cmd_full), 32'(0));
    check_val("rst2_rsp", 32'(rsp_valid), 32'(0));
    check_val("rst2_p0i", 32'(p0_i), 32'(0));
    empty_read;

`ifdef JTCOP_MCU_TIMEOUT_EN
    w = 16'h5A5A;
    push_word(w, i1);
    n = 0;
    while (int1n !== 1'b0 && n < 40) begin
      tick;
      n++;
    end
    n = 0;
    while (int1n === 1'b0 && n < 100) begin
      tick;
      n++;
    end
    void'(model_q.pop_front());
    check_val("tmo_cycles", 32'(n), 32'(16));
    check_val("tmo_err", 32'(mcu_err), 32'(1));
    check_val("tmo_full", 32'(cmd_full), 32'(0));
    empty_read;
    check_val("tmo_sticky", 32'(mcu_err), 32'(1));
`else
    w = 16'h0000;
    check_val("no_err", 32'(mcu_err), 32'(w[0]));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
